// File: rtl/sm_muldiv_pkg.sv
// sm_muldiv_pkg: shared op codes, FSM state encodings and helpers for the
// schoolMIPS iterative multiply/divide unit.
//   MD_*   : 3-bit op codes carried on oper
//   MDS_*  : FSM state encodings (IDLE -> CALC -> FIX -> IDLE)
//   mdFlags_t : per-operation control flags latched when an op is accepted
package sm_muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  localparam logic [1:0] MDS_IDLE = 2'd0;
  localparam logic [1:0] MDS_CALC = 2'd1;
  localparam logic [1:0] MDS_FIX  = 2'd2;

  typedef struct packed {
    logic isDiv;    // divide (else multiply)
    logic negRes;   // product / quotient must be negated
    logic negRem;   // remainder must be negated (signed dividend was negative)
    logic divZero;  // divide with a zero divisor
  } mdFlags_t;

  // MULT and DIV are the signed ops (even codes within the mul/div group)
  function automatic logic isSignedOp(input logic [2:0] op);
    return ~op[0];
  endfunction

  function automatic logic isDivOp(input logic [2:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/sm_muldiv_if.sv
// sm_muldiv_if: request/result bundle between the core and sm_muldiv.
//   master (core): start, oper, srcA, srcB, cancel -> ; <- busy, done, dz, hi, lo
//   slave  (unit): the mirror image
interface sm_muldiv_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  logic [2:0]       oper;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             cancel;
  logic             busy;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, oper, srcA, srcB, cancel,
    input  busy, done, dz, hi, lo
  );

  modport slave (
    input  start, oper, srcA, srcB, cancel,
    output busy, done, dz, hi, lo
  );

endinterface

// File: rtl/sm_muldiv_abs.sv
// sm_muldiv_abs: conditional two's-complement negate of a WIDTH-bit value.
// Used both to take operand magnitudes and to apply the result sign.
//   valIn    : value to (optionally) negate
//   neg      : 1 = output -valIn, 0 = output valIn
//   valOut_c : combinational result
module sm_muldiv_abs #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] valIn,
  input  logic             neg,
  output logic [WIDTH-1:0] valOut_c
);

  assign valOut_c = neg ? WIDTH'(~valIn + WIDTH'(1)) : valIn;

endmodule

// File: rtl/sm_muldiv.sv
// sm_muldiv: iterative multiply/divide unit with HI/LO registers.
// Executes MULT/MULTU/DIV/DIVU in WIDTH+1 busy cycles (WIDTH iterations plus
// a sign-fix cycle) and MTHI/MTLO in a single cycle without raising busy.
//   clk, rst : clock, asynchronous active-high reset
//   md       : sm_muldiv_if slave (start/oper/srcA/srcB/cancel in,
//              busy/done/dz/hi/lo out, all outputs registered)
module sm_muldiv
  import sm_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  sm_muldiv_if.slave md
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [1:0]         state, nextState;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;      // multiply: running product; divide: remainder in low half
  logic [WIDTH-1:0]   sreg;     // multiply: multiplier shifting out; divide: dividend in, quotient out
  logic [WIDTH-1:0]   opB;      // multiplicand / divisor magnitude
  mdFlags_t           flags;
  logic [WIDTH-1:0]   hiReg, loReg;
  logic               busyReg, doneReg, dzReg;

  logic loadOps, doIter, doFix, writeHi, writeLo;

  logic               signA, signB;
  logic [WIDTH-1:0]   aMag, bMag;
  logic [WIDTH:0]     mulSum, mulNext;
  logic [WIDTH:0]     divRem, divDiff;
  logic               divQBit;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quotFix, remFix;

  // operand signs only matter for the signed ops
  assign signA = isSignedOp(md.oper) & md.srcA[WIDTH-1];
  assign signB = isSignedOp(md.oper) & md.srcB[WIDTH-1];

  sm_muldiv_abs #(.WIDTH(WIDTH)) absA (.valIn(md.srcA), .neg(signA), .valOut_c(aMag));
  sm_muldiv_abs #(.WIDTH(WIDTH)) absB (.valIn(md.srcB), .neg(signB), .valOut_c(bMag));

  // result sign fix
  sm_muldiv_abs #(.WIDTH(2*WIDTH)) absP (.valIn(acc),          .neg(flags.negRes), .valOut_c(prodFix));
  sm_muldiv_abs #(.WIDTH(WIDTH))   absQ (.valIn(sreg),         .neg(flags.negRes), .valOut_c(quotFix));
  sm_muldiv_abs #(.WIDTH(WIDTH))   absR (.valIn(acc[WIDTH-1:0]), .neg(flags.negRem), .valOut_c(remFix));

  // shift-add step: add multiplicand into the high half when the multiplier LSB is set
  assign mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opB};
  assign mulNext = sreg[0] ? mulSum : {1'b0, acc[2*WIDTH-1:WIDTH]};

  // restoring step: bit WIDTH of the difference set means the trial subtract underflowed
  assign divRem  = {acc[WIDTH-1:0], sreg[WIDTH-1]};
  assign divDiff = divRem - {1'b0, opB};
  assign divQBit = ~divDiff[WIDTH];

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MDS_IDLE;
    else     state <= nextState;
  end

  // next state and control strobes
  always_comb begin
    nextState = state;
    loadOps   = 1'b0;
    doIter    = 1'b0;
    doFix     = 1'b0;
    writeHi   = 1'b0;
    writeLo   = 1'b0;
    case (state)
      MDS_IDLE: begin
        // cancel also suppresses acceptance of a same-cycle start
        if (md.start && !md.cancel) begin
          case (md.oper)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              loadOps   = 1'b1;
              nextState = MDS_CALC;
            end
            MD_MTHI: writeHi = 1'b1;
            MD_MTLO: writeLo = 1'b1;
            default: ;
          endcase
        end
      end
      MDS_CALC: begin
        if (md.cancel) begin
          nextState = MDS_IDLE;
        end else begin
          doIter = 1'b1;
          if (cnt == '0) nextState = MDS_FIX;
        end
      end
      MDS_FIX: begin
        nextState = MDS_IDLE;
        if (!md.cancel) doFix = 1'b1;
      end
      default: nextState = MDS_IDLE;
    endcase
  end

  // datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      sreg    <= '0;
      opB     <= '0;
      flags   <= '0;
      hiReg   <= '0;
      loReg   <= '0;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
      dzReg   <= 1'b0;
    end else begin
      if (loadOps) begin
        cnt           <= CNT_W'(WIDTH - 1);
        acc           <= '0;
        sreg          <= aMag;
        opB           <= bMag;
        flags.isDiv   <= isDivOp(md.oper);
        flags.negRes  <= signA ^ signB;
        flags.negRem  <= signA;
        flags.divZero <= isDivOp(md.oper) & (md.srcB == '0);
      end

      if (doIter) begin
        cnt <= cnt - CNT_W'(1);
        if (flags.isDiv) begin
          acc[WIDTH-1:0] <= divQBit ? divDiff[WIDTH-1:0] : divRem[WIDTH-1:0];
          sreg           <= {sreg[WIDTH-2:0], divQBit};
        end else begin
          acc  <= {mulNext, acc[WIDTH-1:1]};
          sreg <= sreg >> 1;
        end
      end

      if (doFix) begin
        if (flags.isDiv) begin
          // with a zero divisor the remainder path ends holding |dividend|,
          // so the sign-fixed remainder equals srcA as sampled
          loReg <= flags.divZero ? '1 : quotFix;
          hiReg <= remFix;
        end else begin
          {hiReg, loReg} <= prodFix;
        end
        dzReg <= flags.isDiv & flags.divZero;
      end

      if (writeHi) hiReg <= md.srcA;
      if (writeLo) loReg <= md.srcA;

      doneReg <= doFix | writeHi | writeLo;
      busyReg <= (nextState != MDS_IDLE);
    end
  end

  assign md.busy = busyReg;
  assign md.done = doneReg;
  assign md.dz   = dzReg;
  assign md.hi   = hiReg;
  assign md.lo   = loReg;

endmodule

// File: tb/tb_sm_muldiv.sv
// tb_sm_muldiv: directed-vector bench for sm_muldiv at WIDTH=32 and WIDTH=8.
module tb_sm_muldiv;
  import sm_muldiv_pkg::*;

  logic clk;
  logic rst;

  sm_muldiv_if #(.WIDTH(32)) if32 ();
  sm_muldiv_if #(.WIDTH(8))  if8 ();

  sm_muldiv #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .md(if32.slave));
  sm_muldiv #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .md(if8.slave));

  int nTests = 0;
  int nFail  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one request at the current (post-edge) time; returns in the done cycle.
  // doneN = edges after E0 until done seen, busyN = cycles with busy high.
  task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit intrude, output int doneN, output int busyN);
    if32.start = 1'b1; if32.oper = op; if32.srcA = a; if32.srcB = b;
    @(posedge clk); #1;
    if32.start = 1'b0;
    if32.srcA  = $urandom;
    if32.srcB  = $urandom;
    doneN = 0;
    busyN = 0;
    while (!if32.done && doneN < 200) begin
      if (if32.busy) busyN++;
      if32.start = intrude && (doneN == 5);
      if (intrude) begin
        if32.oper = MD_DIVU; if32.srcA = 32'd100; if32.srcB = 32'd7;
      end
      @(posedge clk); #1;
      doneN++;
    end
    if32.start = 1'b0;
  endtask

  task automatic check32(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo,
                         input logic expDz, input bit intrude = 1'b0);
    int dn, bn;
    run32(op, a, b, intrude, dn, bn);
    checkVal({tag, " done_edge"}, 64'(dn), 64'd33);
    checkVal({tag, " busy_cycles"}, 64'(bn), 64'd33);
    checkVal({tag, " busy_at_done"}, 64'(if32.busy), 64'd0);
    checkVal({tag, " hi"}, 64'(if32.hi), 64'(expHi));
    checkVal({tag, " lo"}, 64'(if32.lo), 64'(expLo));
    checkVal({tag, " dz"}, 64'(if32.dz), 64'(expDz));
  endtask

  task automatic check8(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] expHi, input logic [7:0] expLo,
                        input logic expDz);
    int dn, bn;
    if8.start = 1'b1; if8.oper = op; if8.srcA = a; if8.srcB = b;
    @(posedge clk); #1;
    if8.start = 1'b0;
    if8.srcA  = 8'($urandom);
    if8.srcB  = 8'($urandom);
    dn = 0;
    bn = 0;
    while (!if8.done && dn < 100) begin
      if (if8.busy) bn++;
      @(posedge clk); #1;
      dn++;
    end
    checkVal({tag, " done_edge"}, 64'(dn), 64'd9);
    checkVal({tag, " busy_cycles"}, 64'(bn), 64'd9);
    checkVal({tag, " hi"}, 64'(if8.hi), 64'(expHi));
    checkVal({tag, " lo"}, 64'(if8.lo), 64'(expLo));
    checkVal({tag, " dz"}, 64'(if8.dz), 64'(expDz));
  endtask

  initial begin
    rst = 1'b0;
    if32.start = 1'b0; if32.oper = 3'd0; if32.srcA = '0; if32.srcB = '0; if32.cancel = 1'b0;
    if8.start  = 1'b0; if8.oper  = 3'd0; if8.srcA  = '0; if8.srcB  = '0; if8.cancel  = 1'b0;

    #2 rst = 1'b1;
    #1;
    checkVal("reset busy", 64'(if32.busy), 64'd0);
    checkVal("reset done", 64'(if32.done), 64'd0);
    checkVal("reset dz",   64'(if32.dz),   64'd0);
    checkVal("reset hi",   64'(if32.hi),   64'd0);
    checkVal("reset lo",   64'(if32.lo),   64'd0);
    checkVal("reset hi8",  64'(if8.hi),    64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // main arithmetic, each start issued in the previous op's done cycle
    check32("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    check32("mult_neg",  MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    check32("div_neg",   MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    check32("divu",      MD_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0);
    check32("divu_zero", MD_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 1'b1);
    check32("div_minm1", MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    check32("div_zero",  MD_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);

    // MTHI then MTLO back to back
    if32.start = 1'b1; if32.oper = MD_MTHI; if32.srcA = 32'h00001234;
    @(posedge clk); #1;
    checkVal("mthi hi",   64'(if32.hi),   64'h00001234);
    checkVal("mthi lo",   64'(if32.lo),   64'hFFFFFFFF);
    checkVal("mthi done", 64'(if32.done), 64'd1);
    checkVal("mthi busy", 64'(if32.busy), 64'd0);
    checkVal("mthi dz",   64'(if32.dz),   64'd1);
    if32.oper = MD_MTLO; if32.srcA = 32'h00005678;
    @(posedge clk); #1;
    checkVal("mtlo lo",   64'(if32.lo),   64'h00005678);
    checkVal("mtlo done", 64'(if32.done), 64'd1);
    if32.start = 1'b0;
    @(posedge clk); #1;
    checkVal("mt done_drop", 64'(if32.done), 64'd0);
    checkVal("mt busy_low",  64'(if32.busy), 64'd0);

    // reserved op code is a no-op
    if32.start = 1'b1; if32.oper = 3'b110; if32.srcA = 32'hDEADBEEF;
    @(posedge clk); #1;
    if32.start = 1'b0;
    checkVal("nop busy", 64'(if32.busy), 64'd0);
    checkVal("nop done", 64'(if32.done), 64'd0);
    checkVal("nop hi",   64'(if32.hi),   64'h00001234);
    checkVal("nop lo",   64'(if32.lo),   64'h00005678);

    // start with cancel in IDLE is dropped
    if32.start = 1'b1; if32.cancel = 1'b1; if32.oper = MD_MULTU;
    if32.srcA = 32'd3; if32.srcB = 32'd4;
    @(posedge clk); #1;
    if32.start = 1'b0; if32.cancel = 1'b0;
    checkVal("idle_cancel busy", 64'(if32.busy), 64'd0);
    @(posedge clk); #1;
    checkVal("idle_cancel busy2", 64'(if32.busy), 64'd0);

    // cancel during the 10th CALC cycle of a MULTU
    if32.start = 1'b1; if32.oper = MD_MULTU; if32.srcA = 32'hFFFFFFFF; if32.srcB = 32'd3;
    @(posedge clk); #1;
    if32.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    checkVal("cancel busy_before", 64'(if32.busy), 64'd1);
    if32.cancel = 1'b1;
    @(posedge clk); #1;
    if32.cancel = 1'b0;
    checkVal("cancel busy", 64'(if32.busy), 64'd0);
    checkVal("cancel done", 64'(if32.done), 64'd0);
    checkVal("cancel hi",   64'(if32.hi),   64'h00001234);
    checkVal("cancel lo",   64'(if32.lo),   64'h00005678);
    checkVal("cancel dz",   64'(if32.dz),   64'd1);
    check32("after_cancel", MD_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0);

    // start during busy is ignored; then chain in the done cycle
    check32("intrude", MD_MULTU, 32'd5, 32'd6, 32'h00000000, 32'h0000001E, 1'b0, 1'b1);
    check32("chain",   MD_DIVU,  32'hFFFFFFFF, 32'h10, 32'h0000000F, 32'h0FFFFFFF, 1'b0);

    // asynchronous reset mid-CALC with non-zero state
    check32("pre_rst", MD_DIVU, 32'd9, 32'd0, 32'h00000009, 32'hFFFFFFFF, 1'b1);
    if32.start = 1'b1; if32.oper = MD_MULTU; if32.srcA = 32'd77; if32.srcB = 32'd88;
    @(posedge clk); #1;
    if32.start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    checkVal("arst busy", 64'(if32.busy), 64'd0);
    checkVal("arst done", 64'(if32.done), 64'd0);
    checkVal("arst dz",   64'(if32.dz),   64'd0);
    checkVal("arst hi",   64'(if32.hi),   64'd0);
    checkVal("arst lo",   64'(if32.lo),   64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkVal("arst busy_after", 64'(if32.busy), 64'd0);

    // narrow instance
    check8("w8_multu",   MD_MULTU, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0);
    check8("w8_div_min", MD_DIV,   8'h80, 8'hFF, 8'h00, 8'h80, 1'b0);
    check8("w8_div_neg", MD_DIV,   8'h81, 8'h02, 8'hFF, 8'hC1, 1'b0);
    check8("w8_divu_z",  MD_DIVU,  8'hF0, 8'h00, 8'hF0, 8'hFF, 1'b1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
